// File: rtl/result_fifo_to_bram_packer.sv
// Drains a show-ahead result FIFO and packs RESULT_W-bit results into
// LINE_W-bit BRAM lines. Each result is written into its own slot with byte
// strobes, so writing one slot never touches the others. The producer pointer
// is compared against the host read pointer for full/almost-full
// backpressure. A soft clear restarts a run without a reset.
module result_fifo_to_bram_packer #(
    parameter int RESULT_W           = 16,
    parameter int LINE_W             = 256,
    parameter int DEPTH              = 512,
    parameter int ALMOST_FULL_MARGIN = 64,
    localparam int SLOTS = LINE_W / RESULT_W,
    localparam int CAP   = DEPTH * SLOTS,
    localparam int PTR_W = $clog2(CAP),
    localparam int AW    = $clog2(DEPTH),
    localparam int SW    = $clog2(SLOTS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [RESULT_W-1:0]   i_fifo_rdata,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_ren,
    input  logic                  i_clear,
    input  logic [PTR_W-1:0]      i_rd_ptr,
    output logic                  o_bram_wr_en,
    output logic [AW-1:0]         o_bram_wr_addr,
    output logic [LINE_W-1:0]     o_bram_wr_data,
    output logic [LINE_W/8-1:0]   o_bram_wr_strobe,
    output logic [PTR_W-1:0]      o_wr_ptr,
    output logic [PTR_W:0]        o_used_entries,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_full,
    output logic [RESULT_W-1:0]   o_last_result,
    output logic [31:0]           o_result_count
);

    localparam int BPR = RESULT_W / 8;   // bytes per result
    localparam int NB  = LINE_W / 8;     // bytes per line
    localparam logic [PTR_W:0] CAP_M1   = (PTR_W+1)'(CAP - 1);
    localparam logic [31:0]    MARGIN_U = ALMOST_FULL_MARGIN;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   pop;

    logic                wr_en_reg;
    logic [AW-1:0]       wr_addr_reg;
    logic [LINE_W-1:0]   wr_data_reg;
    logic [NB-1:0]       wr_strobe_reg;
    logic [NB-1:0]       strobe_next;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [RESULT_W-1:0] last_result_reg;
    logic [31:0]         result_count_reg;

    logic [PTR_W-1:0]    used_mod;
    logic [PTR_W:0]      used_entries;
    logic [PTR_W:0]      free_entries;
    logic                full;
    logic [SW-1:0]       slot;

    // Occupancy: pointer difference wraps naturally because CAP is a power of two;
    // one entry stays reserved so full means CAP-1 used.
    assign used_mod     = wr_ptr_reg - i_rd_ptr;
    assign used_entries = {1'b0, used_mod};
    assign free_entries = CAP_M1 - used_entries;
    assign full         = (used_entries == CAP_M1);

    assign slot = wr_ptr_reg[SW-1:0];

    // One byte-lane group per slot; only the group selected by the pointer is enabled.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_strobe
            assign strobe_next[gi*BPR +: BPR] = (slot == SW'(gi)) ? {BPR{1'b1}} : {BPR{1'b0}};
        end
    endgenerate

    // State register: RUN / CLEAR.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and pop strobe; a clear wins over a pop, and nothing pops in reset.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        if (i_clear) begin
            state_next = CLEAR;
        end else begin
            state_next = RUN;
        end
        pop = (state_reg == RUN) && !i_clear && !i_fifo_empty && !full && i_reset_n;
    end

    // Write pipeline: register the popped result as a strobed line write one cycle later.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_en_reg        <= 1'b0;
            wr_addr_reg      <= '0;
            wr_data_reg      <= '0;
            wr_strobe_reg    <= '0;
            wr_ptr_reg       <= '0;
            last_result_reg  <= '0;
            result_count_reg <= '0;
        end else if (i_clear) begin
            wr_en_reg        <= 1'b0;
            wr_ptr_reg       <= '0;
            last_result_reg  <= '0;
            result_count_reg <= '0;
        end else begin
            wr_en_reg <= pop;
            if (pop) begin
                wr_addr_reg     <= wr_ptr_reg[PTR_W-1:SW];
                wr_strobe_reg   <= strobe_next;
                wr_data_reg     <= {SLOTS{i_fifo_rdata}};
                wr_ptr_reg      <= wr_ptr_reg + 1'b1;
                last_result_reg <= i_fifo_rdata;
                if (result_count_reg != 32'hFFFF_FFFF) begin
                    result_count_reg <= result_count_reg + 32'd1;
                end
            end
        end
    end

    assign o_fifo_ren       = pop;
    assign o_bram_wr_en     = wr_en_reg;
    assign o_bram_wr_addr   = wr_addr_reg;
    assign o_bram_wr_data   = wr_data_reg;
    assign o_bram_wr_strobe = wr_strobe_reg;
    assign o_wr_ptr         = wr_ptr_reg;
    assign o_used_entries   = used_entries;
    assign o_empty          = (used_entries == '0);
    assign o_full           = full;
    assign o_almost_full    = (32'(free_entries) <= MARGIN_U);
    assign o_last_result    = last_result_reg;
    assign o_result_count   = result_count_reg;

endmodule

// File: doc/result_fifo_to_bram_packer.md
Name: result_fifo_to_bram_packer

Overview:
Drains a show-ahead result FIFO and packs RESULT_W-bit results into LINE_W-bit BRAM lines using byte strobes. Results are written into consecutive slots, so each line holds SLOTS = LINE_W/RESULT_W results. The block sits between the GEMM engine result FIFO and the host-visible result BRAM. Compared with the fixed 16-bit/256-bit packer, this block adds:
- a parametrised result width, line width and depth;
- host-pointer flow control with full/almost-full backpressure;
- a synchronous soft clear, so back-to-back runs can start without a reset;
- a running result count.

Parameters:
RESULT_W, 16, result width in bits; must be a multiple of 8 and must divide LINE_W.
LINE_W, 256, BRAM line width in bits.
DEPTH, 512, number of BRAM lines; must be a power of two.
ALMOST_FULL_MARGIN, 64, o_almost_full asserts when free entries are at or below this value.
Derived: SLOTS = LINE_W/RESULT_W; CAP = DEPTH*SLOTS; PTR_W = $clog2(CAP); AW = $clog2(DEPTH); SW = $clog2(SLOTS).

Ports:
i_clk  in  1  clock.
i_reset_n  in  1  asynchronous, active-low reset.
i_fifo_rdata  in  RESULT_W  FIFO head data; valid whenever i_fifo_empty=0.
i_fifo_empty  in  1  FIFO empty flag.
o_fifo_ren  out  1  pop strobe; the head is consumed on each cycle this is high.
i_clear  in  1  synchronous soft clear; single-cycle or held.
i_rd_ptr  in  PTR_W  host consumer pointer, in results.
o_bram_wr_en  out  1  BRAM write enable.
o_bram_wr_addr  out  AW  BRAM line address.
o_bram_wr_data  out  LINE_W  write data.
o_bram_wr_strobe  out  LINE_W/8  per-byte write enable.
o_wr_ptr  out  PTR_W  producer pointer, in results.
o_used_entries  out  PTR_W+1  results not yet consumed by the host.
o_empty  out  1  high when o_used_entries==0.
o_full  out  1  high when o_used_entries==CAP-1.
o_almost_full  out  1  high when CAP-1-o_used_entries <= ALMOST_FULL_MARGIN.
o_last_result  out  RESULT_W  most recently written result.
o_result_count  out  32  results written since the last reset or clear; saturates at 0xFFFFFFFF.

Behaviour:
- Reset values (async, i_reset_n=0): all outputs 0 except o_empty=1. The state machine enters RUN.
- States:
  - RUN: normal operation.
  - CLEAR: entered on i_clear=1; stays while i_clear is held; returns to RUN on the first cycle with i_clear=0.
- Pop condition: o_fifo_ren = (state==RUN) & ~i_clear & ~i_fifo_empty & ~o_full. This is combinational.
- Pipeline, on the edge ending a pop cycle N (visible in cycle N+1):
  - o_bram_wr_en <= 1;
  - o_bram_wr_addr <= o_wr_ptr[PTR_W-1:SW];
  - o_bram_wr_strobe <= RESULT_W/8 ones at byte offset o_wr_ptr[SW-1:0]*RESULT_W/8, all other bits 0;
  - o_bram_wr_data <= i_fifo_rdata replicated SLOTS times;
  - o_wr_ptr <= o_wr_ptr+1, mod CAP;
  - o_last_result <= i_fifo_rdata;
  - o_result_count increments.
- A cycle with no pop gives o_bram_wr_en=0 next cycle. Strobe, address and data hold their previous values.
- Latency is 1 cycle from pop to BRAM write. Throughput is 1 result per cycle.
- Slot position is a pure function of o_wr_ptr. A run started after earlier runs, without reset, continues at the next slot. Writing a slot must never alter other slots.
- Occupancy:
  - o_used_entries = (o_wr_ptr - i_rd_ptr) mod CAP, combinational.
  - One entry is reserved, so o_full means CAP-1 entries are used.
  - Popping stops in the same cycle o_full rises, so there is no overflow.
  - An i_rd_ptr advance deasserts o_full combinationally, and popping resumes that cycle.
- Wrap-around: o_wr_ptr goes CAP-1 -> 0, and address DEPTH-1 slot SLOTS-1 is followed by address 0 slot 0.
- i_clear:
  - Suppresses o_fifo_ren that cycle; a clear takes priority over a simultaneous pop.
  - An already-registered write (the pop in the previous cycle) still completes in the clear cycle.
  - The next edge sets o_wr_ptr=0, o_result_count=0, o_last_result=0 and o_bram_wr_en=0.
  - The host is responsible for zeroing i_rd_ptr. BRAM contents are not erased.
- Reset mid-operation: an in-flight write is dropped and no o_bram_wr_en pulse follows reset. The FIFO head is not popped while i_reset_n=0.
- i_fifo_rdata is sampled only in pop cycles; its value is don't-care when i_fifo_empty=1.

Test Plan:
1. Back-to-back without reset: push 0x253E and drain, then push 0x22F7, 0x25B7, 0xA390, 0xA40A. Required:
   - line0 bits [15:0]=0x253E, [31:16]=0x22F7, [47:32]=0x25B7, [63:48]=0xA390, [79:64]=0xA40A;
   - exactly 5 writes, with strobes 0x3, 0xC, 0x30, 0xC0, 0x300;
   - o_wr_ptr=5, o_used_entries=5.
2. Line crossing: 17 consecutive results 0x0000..0x0010 with one pop per cycle. Required: 16 writes to addr0 with strobes 0x3<<2k, then addr1 strobe 0x3 data 0x0010; o_result_count=17; each write 1 cycle after its pop.
3. Backpressure: hold i_rd_ptr=0 with the FIFO always non-empty. Required:
   - pops stop at o_wr_ptr=8191 with o_full=1;
   - o_almost_full first asserts at used=8127;
   - stepping i_rd_ptr to 1 gives exactly one more pop, o_wr_ptr wraps to 0, and o_full re-asserts.
4. Clear mid-stream: assert i_clear in the cycle the 3rd of 6 results would pop. Required:
   - results 1-2 are written, and no pop occurs in the clear cycle;
   - after release, o_wr_ptr resumes from 0 and result 3 lands at addr0 strobe 0x3;
   - o_result_count resumes from 0.
5. Reset mid-stream: drop i_reset_n during a pop cycle. Required: all outputs return to reset values immediately, with no o_bram_wr_en afterwards until a new pop.
6. Parameter sweep with RESULT_W=32, LINE_W=128, DEPTH=16. Required: 4 slots per line, strobes 0xF, 0xF0, 0xF00, 0xF000; o_full at used=63.
